// File: rtl/glut_ctrl_pkg.sv
// rtl/glut_ctrl_pkg.sv - select encodings, cfg_word layout, FSM states and one-hot check for the glut sequencer
package glut_ctrl_pkg;

    localparam logic [2:0] SEL_EAST  = 3'b001;
    localparam logic [2:0] SEL_NORTH = 3'b010;
    localparam logic [2:0] SEL_SOUTH = 3'b100;

    // cfg_word = {block_en, input_sel_a[2:0], input_sel_b[2:0], output_sel[2:0]}
    localparam int CFG_W        = 10;
    localparam int CFG_EN_BIT   = 9;
    localparam int CFG_SELA_LSB = 6;
    localparam int CFG_SELB_LSB = 3;
    localparam int CFG_OUT_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_FIN
    } seq_state_t;

    function automatic logic sel_is_onehot(input logic [2:0] sel);
        return (sel == SEL_EAST) || (sel == SEL_NORTH) || (sel == SEL_SOUTH);
    endfunction

endpackage

// File: rtl/glut_stage_desc_ram.sv
// rtl/glut_stage_desc_ram.sv - stage descriptor storage: per-block routing words plus burst/drain lengths
module glut_stage_desc_ram
    import glut_ctrl_pkg::*;
#(
    parameter int NBLK   = 4,
    parameter int NSTAGE = 8,
    parameter int LEN_W  = 16,
    parameter int DRN_W  = 8,
    localparam int SW    = $clog2(NSTAGE),
    localparam int BW    = $clog2(NBLK)
) (
    input  logic                    clk,
    input  logic                    cfg_we_i,
    input  logic [SW-1:0]           cfg_stage_i,
    input  logic [BW-1:0]           cfg_blk_i,
    input  logic [CFG_W-1:0]        cfg_word_i,
    input  logic                    len_we_i,
    input  logic [SW-1:0]           len_stage_i,
    input  logic [LEN_W-1:0]        len_beats_i,
    input  logic [DRN_W-1:0]        len_drain_i,
    input  logic [SW-1:0]           rd_stage_i,
    output logic [NBLK*CFG_W-1:0]   rd_cfg_o,
    output logic [LEN_W-1:0]        rd_beats_o,
    output logic [DRN_W-1:0]        rd_drain_o
);

    // Contents are deliberately not reset; software programs every used slot.
    logic [NBLK*CFG_W-1:0]   cfg_mem [NSTAGE];
    logic [LEN_W+DRN_W-1:0]  len_mem [NSTAGE];

    always_ff @(posedge clk) begin
        if (cfg_we_i) begin
            cfg_mem[cfg_stage_i][cfg_blk_i*CFG_W +: CFG_W] <= cfg_word_i;
        end
        if (len_we_i) begin
            len_mem[len_stage_i] <= {len_beats_i, len_drain_i};
        end
    end

    assign rd_cfg_o                 = cfg_mem[rd_stage_i];
    assign {rd_beats_o, rd_drain_o} = len_mem[rd_stage_i];

endmodule

// File: rtl/glut_stage_sequencer.sv
// rtl/glut_stage_sequencer.sv - steps a glut block chain through programmed stages, driving routing and stage_start
module glut_stage_sequencer
    import glut_ctrl_pkg::*;
#(
    parameter int NBLK   = 4,
    parameter int NSTAGE = 8,
    parameter int LEN_W  = 16,
    parameter int DRN_W  = 8,
    localparam int SW    = $clog2(NSTAGE),
    localparam int BW    = $clog2(NBLK)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we_i,
    input  logic [SW-1:0]       cfg_stage_i,
    input  logic [BW-1:0]       cfg_blk_i,
    input  logic [CFG_W-1:0]    cfg_word_i,
    input  logic                len_we_i,
    input  logic [SW-1:0]       len_stage_i,
    input  logic [LEN_W-1:0]    len_beats_i,
    input  logic [DRN_W-1:0]    len_drain_i,
    input  logic [SW:0]         num_stages_i,
    input  logic                start_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                aborted_o,
    output logic                cfg_err_o,
    output logic [SW-1:0]       cur_stage_o,
    output logic                src_ready_o,
    output logic [NBLK-1:0]     stage_start_o,
    output logic [NBLK-1:0]     block_en_o,
    output logic [3*NBLK-1:0]   input_sel_a_o,
    output logic [3*NBLK-1:0]   input_sel_b_o,
    output logic [3*NBLK-1:0]   output_sel_o
);

    seq_state_t          state_q;
    logic [SW-1:0]       stage_q;
    logic [SW:0]         num_q;
    logic [LEN_W-1:0]    beats_q;
    logic [DRN_W-1:0]    drain_q;
    logic                busy_q, done_q, aborted_q, cfg_err_q, src_ready_q;
    logic [NBLK-1:0]     stage_start_q, block_en_q;
    logic [3*NBLK-1:0]   sel_a_q, sel_b_q, out_sel_q;

    logic [SW-1:0]       rd_idx;
    logic [NBLK*CFG_W-1:0] rd_cfg;
    logic [LEN_W-1:0]    rd_beats;
    logic [DRN_W-1:0]    rd_drain;
    logic [SW:0]         stage_inc;
    logic                last_stage, run_last, goto_load, cfg_bad;
    logic [NBLK-1:0]     ld_en;
    logic [3*NBLK-1:0]   ld_sel_a, ld_sel_b, ld_out;

    glut_stage_desc_ram #(
        .NBLK   (NBLK),
        .NSTAGE (NSTAGE),
        .LEN_W  (LEN_W),
        .DRN_W  (DRN_W)
    ) u_desc_ram (
        .clk         (clk),
        .cfg_we_i    (cfg_we_i && (state_q == ST_IDLE)),
        .cfg_stage_i (cfg_stage_i),
        .cfg_blk_i   (cfg_blk_i),
        .cfg_word_i  (cfg_word_i),
        .len_we_i    (len_we_i && (state_q == ST_IDLE)),
        .len_stage_i (len_stage_i),
        .len_beats_i (len_beats_i),
        .len_drain_i (len_drain_i),
        .rd_stage_i  (rd_idx),
        .rd_cfg_o    (rd_cfg),
        .rd_beats_o  (rd_beats),
        .rd_drain_o  (rd_drain)
    );

    // The RAM is read for the stage being entered, so routing is already valid during LOAD.
    assign stage_inc  = {1'b0, stage_q} + (SW+1)'(1);
    assign last_stage = (stage_inc == num_q);
    assign rd_idx     = (state_q == ST_IDLE) ? '0 : stage_inc[SW-1:0];
    assign run_last   = ((beats_q == LEN_W'(1)) && (drain_q == '0)) ||
                        ((beats_q == '0) && (drain_q == DRN_W'(1)));

    always_comb begin
        goto_load = 1'b0;
        case (state_q)
            ST_IDLE: goto_load = start_i && (num_stages_i != '0);
            ST_LOAD: goto_load = (beats_q == '0) && !last_stage;
            ST_RUN:  goto_load = run_last && !last_stage;
            default: goto_load = 1'b0;
        endcase
    end

    always_comb begin
        cfg_bad  = 1'b0;
        ld_en    = '0;
        ld_sel_a = '0;
        ld_sel_b = '0;
        ld_out   = '0;
        for (int i = 0; i < NBLK; i++) begin
            ld_en[i]          = rd_cfg[i*CFG_W + CFG_EN_BIT];
            ld_sel_a[3*i +: 3] = rd_cfg[i*CFG_W + CFG_SELA_LSB +: 3];
            ld_sel_b[3*i +: 3] = rd_cfg[i*CFG_W + CFG_SELB_LSB +: 3];
            ld_out[3*i +: 3]   = rd_cfg[i*CFG_W + CFG_OUT_LSB +: 3];
            if (ld_en[i] && (!sel_is_onehot(ld_sel_a[3*i +: 3]) ||
                             !sel_is_onehot(ld_sel_b[3*i +: 3]))) begin
                cfg_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            stage_q       <= '0;
            num_q         <= '0;
            beats_q       <= '0;
            drain_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            cfg_err_q     <= 1'b0;
            src_ready_q   <= 1'b0;
            stage_start_q <= '0;
            block_en_q    <= '0;
            sel_a_q       <= '0;
            sel_b_q       <= '0;
            out_sel_q     <= '0;
        end else if (abort_i && (state_q != ST_IDLE)) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b1;
            src_ready_q   <= 1'b0;
            stage_start_q <= '0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        num_q <= num_stages_i;
                        if (num_stages_i == '0) begin
                            state_q   <= ST_FIN;
                            done_q    <= 1'b1;
                            cfg_err_q <= 1'b0;
                        end else begin
                            state_q <= ST_LOAD;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (beats_q == '0) begin
                        if (last_stage) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        state_q       <= ST_RUN;
                        stage_start_q <= '1;
                        src_ready_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (run_last) begin
                        stage_start_q <= '0;
                        src_ready_q   <= 1'b0;
                        if (last_stage) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end else begin
                        src_ready_q <= (beats_q > LEN_W'(1));
                        if (beats_q != '0) begin
                            beats_q <= beats_q - LEN_W'(1);
                        end else begin
                            drain_q <= drain_q - DRN_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (goto_load) begin
                stage_q    <= rd_idx;
                beats_q    <= rd_beats;
                drain_q    <= rd_drain;
                block_en_q <= ld_en;
                sel_a_q    <= ld_sel_a;
                sel_b_q    <= ld_sel_b;
                out_sel_q  <= ld_out;
                cfg_err_q  <= (state_q == ST_IDLE) ? cfg_bad : (cfg_err_q | cfg_bad);
            end
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign aborted_o     = aborted_q;
    assign cfg_err_o     = cfg_err_q;
    assign cur_stage_o   = stage_q;
    assign src_ready_o   = src_ready_q;
    assign stage_start_o = stage_start_q;
    assign block_en_o    = block_en_q;
    assign input_sel_a_o = sel_a_q;
    assign input_sel_b_o = sel_b_q;
    assign output_sel_o  = out_sel_q;

endmodule

// File: doc/glut_stage_sequencer.md
Name: glut_stage_sequencer

Overview:
- Programmable controller for a chain of NBLK basic_block_x4 compute blocks (ADD/MUL/EXP/... patterns).
- Holds up to NSTAGE stage descriptors, each with per-block routing config, a burst length and a drain length.
- On start, steps through the stages in order. For each stage it drives every block's block_en, input_sel_a, input_sel_b, output_sel and stage_start, and it asks the upstream source for data beats.
- Sits between the host config/register interface and the glut array.

Parameters:
NBLK, 4, number of compute blocks controlled
NSTAGE, 8, descriptor slots; SW = clog2(NSTAGE), BW = clog2(NBLK)
LEN_W, 16, width of burst-length field
DRN_W, 8, width of drain-length field (covers pipeline latency of the slowest pattern)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
cfg_we  in  1  write one block-config word
cfg_stage  in  SW  target stage of cfg write
cfg_blk  in  BW  target block of cfg write
cfg_word  in  10  {block_en, input_sel_a[2:0], input_sel_b[2:0], output_sel[2:0]}
len_we  in  1  write stage lengths
len_stage  in  SW  target stage of len write
len_beats  in  LEN_W  data beats requested in the stage
len_drain  in  DRN_W  extra cycles stage_start is held after the last beat
num_stages  in  SW+1  stages to run, 0..NSTAGE, sampled at start
start  in  1  launch the program (pulse)
abort  in  1  terminate the program (pulse)
busy  out  1  program in progress
done  out  1  one-cycle pulse on normal completion
aborted  out  1  one-cycle pulse on abort
cfg_err  out  1  sticky flag: a non-one-hot select was loaded
cur_stage  out  SW  index of the active stage
src_ready  out  1  upstream may present a data beat this cycle
stage_start  out  NBLK  per-block stage_start
block_en  out  NBLK  per-block enable
input_sel_a  out  3*NBLK  block i at bits [3i+2:3i]
input_sel_b  out  3*NBLK  same packing
output_sel  out  3*NBLK  same packing

Behaviour:
- Reset: all outputs 0; FSM in IDLE; descriptor RAM contents are don't-care (it is not reset).
- FSM states: IDLE, LOAD, RUN, FIN.
- IDLE:
  - cfg_we/len_we write the descriptor RAM.
  - start with num_stages=0 -> FIN next cycle.
  - start with num_stages>0 -> LOAD with stage index 0.
- Writes while busy are ignored; start while busy is ignored.
- LOAD (1 cycle):
  - busy=1, stage_start=0.
  - Registered control outputs take the stage's config.
  - Beat counter loads len_beats and drain counter loads len_drain.
  - If len_beats==0, the stage is skipped: go to LOAD of the next stage, or FIN if it was the last.
  - Otherwise -> RUN.
- Control outputs change only in LOAD, never while stage_start=1.
- RUN:
  - stage_start = all ones; busy=1.
  - src_ready=1 for the first len_beats cycles, then 0 for len_drain cycles.
  - Stage length is exactly len_beats+len_drain cycles, so results draining from the pipeline are captured while stage_start is still high.
- End of RUN: go to LOAD of the next stage, which also gives a 1-cycle stage_start=0 gap that flushes block registers. After the last stage -> FIN.
- FIN (1 cycle): done=1, busy=0, stage_start=0, cur_stage holds its last value -> IDLE.
- abort in any non-IDLE state:
  - Next cycle: IDLE, stage_start=0, src_ready=0, busy=0, aborted=1, no done pulse.
  - abort and start in the same cycle in IDLE: start wins, abort ignored.
- cfg_err:
  - Set in LOAD if any enabled block has an input_sel_a, or an input_sel_b, that is not one-hot (000 counts as illegal).
  - The stage still runs; the flag clears only on reset or a new start.
- Blocks with block_en=0 still receive stage_start (bypass path).
- Counters: beat and drain counters are down-counters; no wrap. The stage index saturates at num_stages-1.
- Reset asserted mid-run: all outputs 0 on the next edge; no done or aborted pulse.

Decomposition:
- Package glut_ctrl_pkg holds:
  - sel encodings SEL_EAST=3'b001, SEL_NORTH=3'b010, SEL_SOUTH=3'b100;
  - the cfg_word field offsets;
  - FSM state enum;
  - the one-hot check function.
- Sub-module glut_stage_desc_ram holds descriptors: NSTAGE×NBLK×10 config bits plus NSTAGE×(LEN_W+DRN_W) length bits, with a synchronous write port and one combinational read port indexed by stage.

Test Plan:
1. Program stage0: all blocks cfg 1_001_010_001, beats=4, drain=3; num_stages=1; start at cycle 0 -> LOAD at cycle 1; stage_start high cycles 2–8; src_ready high cycles 2–5; done pulse at cycle 9; busy low at cycle 9.
2. Two stages (beats 2/drain 1, then beats 3/drain 0), with block1 input_sel_a=100 in stage 1 -> exactly one stage_start=0 cycle between stages; input_sel_a[5:3] changes only in that gap cycle; cur_stage goes 0 then 1.
3. Stage 1 has beats=0 and num_stages=3 -> stage 1 produces no stage_start cycles; stage 2 begins right after stage 1's LOAD; done fires once.
4. abort in the 3rd RUN cycle -> next cycle stage_start=0, busy=0, aborted=1, done never asserts; a following start reruns from stage 0.
5. Load input_sel_b=011 for an enabled block -> cfg_err=1 after LOAD and stays 1 through done; cleared on the next start with legal config.
6. Edge cases:
   - num_stages=0 -> done one cycle after start, with no stage_start.
   - start and cfg_we while busy -> both ignored; RAM read back unchanged.
   - rst_n low mid-RUN -> all outputs 0 on the next edge.
